// File: rtl/utf8_stream_decoder_if.sv
// Byte-in / code-point-out handshake bundle for utf8_stream_decoder.
// master drives bytes and consumer readiness; slave is the decoder.
interface utf8_stream_decoder_if;
  logic [7:0]  byte_in;
  logic        byte_available;
  logic        byte_ready;
  logic        consumer_ready;
  logic [20:0] unicode;
  logic        unicode_available;
  logic        overflow;

  modport master (
    output byte_in, byte_available, consumer_ready,
    input  byte_ready, unicode, unicode_available, overflow
  );

  modport slave (
    input  byte_in, byte_available, consumer_ready,
    output byte_ready, unicode, unicode_available, overflow
  );
endinterface

// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte stream to 21-bit code points, U+FFFD on malformed input, FIFO-buffered strobed output.
// Optional macro UTF8_STRICT_EN adds second-byte range checks (overlong, surrogate, > U+10FFFF).
module utf8_stream_decoder #(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             reset_n,
  utf8_stream_decoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [20:0]   REPL = 21'h00FFFD;

  typedef enum logic [1:0] {
    DEC_IDLE   = 2'd0,
    DEC_CONT   = 2'd1,
    DEC_REPLAY = 2'd2
  } dec_state_t;

  dec_state_t  r_state, w_state_next;
  logic [1:0]  r_rem, w_rem_next;
  logic [20:0] r_acc, w_acc_next;
  logic [7:0]  r_hold, w_hold_next;

  logic [20:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [20:0] r_unicode;
  logic        r_unicode_available;
  logic        r_overflow;

  logic        w_byte_ready, w_accept, w_proc, w_pop, w_push;
  logic [20:0] w_push_data;
  logic [7:0]  w_byte;
  logic        w_is_ascii, w_is_lead2, w_is_lead3, w_is_lead4, w_cont_ok, w_strict_ok;

  assign w_byte_ready = (r_count < FULL) && (r_state != DEC_REPLAY);
  assign w_accept     = bus.byte_available && w_byte_ready;
  // A replayed byte waits for FIFO room, since it may itself push a code point.
  assign w_proc       = (r_state == DEC_REPLAY) ? (r_count != FULL) : w_accept;
  assign w_byte       = (r_state == DEC_REPLAY) ? r_hold : bus.byte_in;
  assign w_pop        = (r_count != {CW{1'b0}}) && bus.consumer_ready && !r_unicode_available;

  assign w_is_ascii = ~w_byte[7];
  assign w_is_lead2 = (w_byte >= 8'hC2) && (w_byte <= 8'hDF);
  assign w_is_lead3 = (w_byte[7:4] == 4'hE);
  assign w_is_lead4 = (w_byte >= 8'hF0) && (w_byte <= 8'hF4);
  assign w_cont_ok  = (w_byte[7:6] == 2'b10) && w_strict_ok;

`ifdef UTF8_STRICT_EN
  logic [7:0] r_lead, w_lead_next;
  logic       r_first, w_first_next;

  // Range check applied only to the byte right after the lead.
  always_comb begin
    w_strict_ok = 1'b1;
    if (r_first) begin
      case (r_lead)
        8'hE0:   w_strict_ok = (w_byte >= 8'hA0);
        8'hED:   w_strict_ok = (w_byte <= 8'h9F);
        8'hF0:   w_strict_ok = (w_byte >= 8'h90);
        8'hF4:   w_strict_ok = (w_byte <= 8'h8F);
        default: w_strict_ok = 1'b1;
      endcase
    end else begin
      w_strict_ok = 1'b1;
    end
  end

  // Lead byte and first-continuation flag for the strict check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lead  <= 8'h00;
      r_first <= 1'b0;
    end else begin
      r_lead  <= w_lead_next;
      r_first <= w_first_next;
    end
  end
`else
  assign w_strict_ok = 1'b1;
`endif

  // Decoder state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DEC_IDLE;
      r_rem   <= 2'd0;
      r_acc   <= 21'd0;
      r_hold  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      r_acc   <= w_acc_next;
      r_hold  <= w_hold_next;
    end
  end

  // Decoder next-state.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_acc_next   = r_acc;
    w_hold_next  = r_hold;
`ifdef UTF8_STRICT_EN
    w_lead_next  = r_lead;
    w_first_next = r_first;
`endif
    if (w_proc) begin
      case (r_state)
        DEC_IDLE, DEC_REPLAY: begin
          w_state_next = DEC_IDLE;
`ifdef UTF8_STRICT_EN
          w_lead_next  = w_byte;
          w_first_next = 1'b1;
`endif
          if (w_is_lead2) begin
            w_state_next = DEC_CONT;
            w_rem_next   = 2'd1;
            w_acc_next   = {16'd0, w_byte[4:0]};
          end else if (w_is_lead3) begin
            w_state_next = DEC_CONT;
            w_rem_next   = 2'd2;
            w_acc_next   = {17'd0, w_byte[3:0]};
          end else if (w_is_lead4) begin
            w_state_next = DEC_CONT;
            w_rem_next   = 2'd3;
            w_acc_next   = {18'd0, w_byte[2:0]};
          end else begin
            w_state_next = DEC_IDLE;
          end
        end
        DEC_CONT: begin
          if (w_cont_ok) begin
            w_acc_next   = (r_acc << 3'd6) | {15'd0, w_byte[5:0]};
            w_rem_next   = r_rem - 2'd1;
            w_state_next = (r_rem == 2'd1) ? DEC_IDLE : DEC_CONT;
`ifdef UTF8_STRICT_EN
            w_first_next = 1'b0;
`endif
          end else begin
            w_state_next = DEC_REPLAY;
            w_hold_next  = w_byte;
          end
        end
        default: w_state_next = DEC_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Decoder output: what, if anything, goes into the FIFO this cycle.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 21'd0;
    if (w_proc) begin
      case (r_state)
        DEC_IDLE, DEC_REPLAY: begin
          if (w_is_ascii) begin
            w_push      = 1'b1;
            w_push_data = {13'd0, w_byte};
          end else if (w_is_lead2 || w_is_lead3 || w_is_lead4) begin
            w_push      = 1'b0;
          end else begin
            w_push      = 1'b1;
            w_push_data = REPL;
          end
        end
        DEC_CONT: begin
          if (!w_cont_ok) begin
            w_push      = 1'b1;
            w_push_data = REPL;
          end else if (r_rem == 2'd1) begin
            w_push      = 1'b1;
            w_push_data = (r_acc << 3'd6) | {15'd0, w_byte[5:0]};
          end else begin
            w_push      = 1'b0;
          end
        end
        default: w_push = 1'b0;
      endcase
    end else begin
      w_push = 1'b0;
    end
  end

  // FIFO storage; emptiness is tracked by pointers/count so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  // FIFO pointers, count and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr              <= {AW{1'b0}};
      r_rptr              <= {AW{1'b0}};
      r_count             <= {CW{1'b0}};
      r_unicode           <= 21'd0;
      r_unicode_available <= 1'b0;
      r_overflow          <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_unicode <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_unicode_available <= w_pop;
      r_overflow          <= r_overflow | (bus.byte_available & ~w_byte_ready);
    end
  end

  assign bus.byte_ready        = w_byte_ready;
  assign bus.unicode           = r_unicode;
  assign bus.unicode_available = r_unicode_available;
  assign bus.overflow          = r_overflow;
endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed bench for utf8_stream_decoder: vector table plus hand-written
// interrupt, backpressure/overflow and reset sequences.
module tb_utf8_stream_decoder;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [20:0] got[$];
  int   scyc[$];

  utf8_stream_decoder_if bus();

  utf8_stream_decoder #(.DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every code point and the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.unicode_available === 1'b1) begin
      got.push_back(bus.unicode);
      scyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [3:0][7:0]  b;
    int               nb;
    logic [3:0][20:0] e;
    int               ne;
    bit               lat;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input int nb, input logic [7:0] b0, b1, b2, b3,
                              input int ne, input logic [20:0] e0, e1, e2, e3,
                              input bit lat);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.nb = nb; v.ne = ne; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_in = b;
    bus.byte_available = 1'b1;
    while (!bus.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=byte_ready_low required=byte_ready_high");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.byte_available = 1'b0;
  endtask

  task automatic wait_codes(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_codes(input string name, input logic [3:0][20:0] e, input int ne);
    chk({name, "_count"}, got.size(), ne);
    for (int j = 0; j < ne; j++) begin
      chk({name, "_code"}, (j < got.size()) ? {11'd0, got[j]} : 32'hFFFF_FFFF, {11'd0, e[j]});
    end
  endtask

  task automatic check_spacing(input string name);
    int bad;
    bad = 0;
    for (int j = 1; j < scyc.size(); j++) begin
      if (scyc[j] - scyc[j-1] < 2) bad++;
    end
    chk({name, "_spacing"}, bad, 0);
  endtask

  initial begin
    int a;
    int hi;
    logic r16;
    logic [3:0][20:0] ex;

    tbl[0] = mk(1, 8'h41, 8'h00, 8'h00, 8'h00, 1, 21'h41, 21'h0, 21'h0, 21'h0, 1'b1);
    tbl[1] = mk(2, 8'hC3, 8'hA9, 8'h00, 8'h00, 1, 21'hE9, 21'h0, 21'h0, 21'h0, 1'b1);
    tbl[2] = mk(3, 8'hE2, 8'h82, 8'hAC, 8'h00, 1, 21'h20AC, 21'h0, 21'h0, 21'h0, 1'b1);
    tbl[3] = mk(4, 8'hF0, 8'h9F, 8'h98, 8'h80, 1, 21'h1F600, 21'h0, 21'h0, 21'h0, 1'b1);
    tbl[4] = mk(2, 8'hC3, 8'h41, 8'h00, 8'h00, 2, 21'hFFFD, 21'h41, 21'h0, 21'h0, 1'b0);
    tbl[6] = mk(1, 8'h80, 8'h00, 8'h00, 8'h00, 1, 21'hFFFD, 21'h0, 21'h0, 21'h0, 1'b0);
    tbl[7] = mk(2, 8'hC0, 8'hF5, 8'h00, 8'h00, 2, 21'hFFFD, 21'hFFFD, 21'h0, 21'h0, 1'b0);
    tbl[10] = mk(3, 8'hE2, 8'h28, 8'hA1, 8'h00, 3, 21'hFFFD, 21'h28, 21'hFFFD, 21'h0, 1'b0);
    tbl[11] = mk(3, 8'hF0, 8'h9F, 8'h41, 8'h00, 2, 21'hFFFD, 21'h41, 21'h0, 21'h0, 1'b0);
`ifdef UTF8_STRICT_EN
    tbl[5] = mk(3, 8'hE0, 8'h80, 8'h80, 8'h00, 3, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'h0, 1'b0);
    tbl[8] = mk(3, 8'hED, 8'hA0, 8'h80, 8'h00, 3, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'h0, 1'b0);
    tbl[9] = mk(4, 8'hF4, 8'h90, 8'h80, 8'h80, 4, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'hFFFD, 1'b0);
`else
    tbl[5] = mk(3, 8'hE0, 8'h80, 8'h80, 8'h00, 1, 21'h0, 21'h0, 21'h0, 21'h0, 1'b0);
    tbl[8] = mk(3, 8'hED, 8'hA0, 8'h80, 8'h00, 1, 21'hD800, 21'h0, 21'h0, 21'h0, 1'b0);
    tbl[9] = mk(4, 8'hF4, 8'h90, 8'h80, 8'h80, 1, 21'h110000, 21'h0, 21'h0, 21'h0, 1'b0);
`endif

    reset_n = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_available = 1'b0;
    bus.consumer_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_unicode", {11'd0, bus.unicode}, 32'h0);
    chk("rst_avail", {31'd0, bus.unicode_available}, 32'h0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'h0);
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'h1);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      got.delete();
      scyc.delete();
      for (int j = 0; j < tbl[i].nb; j++) send_byte(tbl[i].b[j], a);
      wait_codes(tbl[i].ne);
      check_codes($sformatf("vec%0d", i), tbl[i].e, tbl[i].ne);
      check_spacing($sformatf("vec%0d", i));
      if (tbl[i].lat) chk($sformatf("vec%0d_latency", i), (scyc.size() > 0) ? scyc[0] - a : -1, 2);
    end

    // Interrupted sequence: byte_ready drops for exactly the replay cycle.
    got.delete();
    scyc.delete();
    send_byte(8'hC3, a);
    send_byte(8'h41, a);
    @(negedge clk);
    chk("replay_ready_low", {31'd0, bus.byte_ready}, 32'h0);
    @(negedge clk);
    chk("replay_ready_high", {31'd0, bus.byte_ready}, 32'h1);
    wait_codes(2);
    ex = {21'h0, 21'h0, 21'h41, 21'hFFFD};
    check_codes("replay", ex, 2);

    // Backpressure: 17 back-to-back bytes with the consumer stalled.
    got.delete();
    scyc.delete();
    bus.consumer_ready = 1'b0;
    hi = 0;
    r16 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.byte_in = 8'h41 + 8'(i);
      bus.byte_available = 1'b1;
      if (i < 16) hi += int'(bus.byte_ready);
      else r16 = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    bus.byte_available = 1'b0;
    @(negedge clk);
    chk("bp_ready_first16", hi, 16);
    chk("bp_ready_17th", {31'd0, r16}, 32'h0);
    chk("bp_overflow", {31'd0, bus.overflow}, 32'h1);
    chk("bp_no_strobe", got.size(), 0);
    bus.consumer_ready = 1'b1;
    wait_codes(16);
    chk("bp_count", got.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("bp_code", (i < got.size()) ? {11'd0, got[i]} : 32'hFFFF_FFFF, 32'h41 + i);
    end
    check_spacing("bp");
    chk("bp_ready_back", {31'd0, bus.byte_ready}, 32'h1);
    chk("bp_overflow_sticky", {31'd0, bus.overflow}, 32'h1);

    // Reset in the middle of a three-byte sequence.
    got.delete();
    scyc.delete();
    send_byte(8'hE2, a);
    send_byte(8'h82, a);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_unicode", {11'd0, bus.unicode}, 32'h0);
    chk("mid_rst_avail", {31'd0, bus.unicode_available}, 32'h0);
    chk("mid_rst_overflow", {31'd0, bus.overflow}, 32'h0);
    chk("mid_rst_byte_ready", {31'd0, bus.byte_ready}, 32'h1);
    reset_n = 1'b1;
    send_byte(8'h41, a);
    wait_codes(1);
    ex = {21'h0, 21'h0, 21'h0, 21'h41};
    check_codes("post_rst", ex, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
